// File: rtl/qsys_cpu_cpu_mul_combine_if.sv
// rtl/qsys_cpu_cpu_mul_combine_if.sv - M-stage partial products in, W-stage multiply result out
interface qsys_cpu_cpu_mul_combine_if #(
  parameter int DST_W = 5
);
  logic             M_en;
  logic             A_en;
  logic             M_valid;
  logic             M_ctrl_mul_lsw;
  logic [DST_W-1:0] M_dst_regnum;
  logic [31:0]      M_mul_cell_p1;
  logic [31:0]      M_mul_cell_p2;
  logic [31:0]      M_mul_cell_p3;
  logic             A_flush;
  logic             A_mul_busy;
  logic             W_mul_wr_en;
  logic [DST_W-1:0] W_dst_regnum;
  logic [31:0]      W_mul_result;
  logic [31:0]      mul_count;

  modport master (
    output M_en, A_en, M_valid, M_ctrl_mul_lsw, M_dst_regnum,
           M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, A_flush,
    input  A_mul_busy, W_mul_wr_en, W_dst_regnum, W_mul_result, mul_count
  );

  modport slave (
    input  M_en, A_en, M_valid, M_ctrl_mul_lsw, M_dst_regnum,
           M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, A_flush,
    output A_mul_busy, W_mul_wr_en, W_dst_regnum, W_mul_result, mul_count
  );
endinterface

// File: rtl/qsys_cpu_cpu_mul_combine.sv
// rtl/qsys_cpu_cpu_mul_combine.sv - reduces 16x16 partial products to the 32-bit low-word product over A/W
// Optional completed-multiply counter enabled by defining QSYS_CPU_MUL_PERF_CNT_EN.
module qsys_cpu_cpu_mul_combine #(
  parameter int DST_W        = 5,
  parameter int PIPE_COMBINE = 1
) (
  input logic                         clk,
  input logic                         reset_n,
  qsys_cpu_cpu_mul_combine_if.slave   bus
);

  logic             a_valid;
  logic [DST_W-1:0] a_dst;
  logic [31:0]      a_data;
  logic [31:0]      a_data_d;

  // Only the low 16 bits of p2/p3 reach the low product word; their upper halves weigh 2^32 and up.
  generate
    if (PIPE_COMBINE != 0) begin : g_split
      logic [15:0] hi_sum;
      always_comb begin
        hi_sum   = bus.M_mul_cell_p1[31:16] + bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];
        a_data_d = {hi_sum, bus.M_mul_cell_p1[15:0]};
      end
    end else begin : g_full
      always_comb begin
        a_data_d = bus.M_mul_cell_p1
                 + ((bus.M_mul_cell_p2 + bus.M_mul_cell_p3) << 16);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid <= 1'b0;
      a_dst   <= '0;
      a_data  <= '0;
    end else if (bus.M_en) begin
      a_valid <= bus.M_valid & bus.M_ctrl_mul_lsw & ~bus.A_flush;
      a_dst   <= bus.M_dst_regnum;
      a_data  <= a_data_d;
    end else if (bus.A_flush) begin
      a_valid <= 1'b0;
    end
  end

  logic             w_wr_en;
  logic [DST_W-1:0] w_dst;
  logic [31:0]      w_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_wr_en  <= 1'b0;
      w_dst    <= '0;
      w_result <= '0;
    end else if (bus.A_en) begin
      w_wr_en  <= a_valid & ~bus.A_flush;
      w_dst    <= a_dst;
      w_result <= {a_data[31:16], a_data[15:0]};
    end else if (bus.A_flush) begin
      w_wr_en  <= 1'b0;
    end
  end

`ifdef QSYS_CPU_MUL_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (bus.A_en && a_valid && !bus.A_flush) begin
      cnt <= cnt + 32'd1;
    end
  end
  assign bus.mul_count = cnt;
`else
  assign bus.mul_count = 32'd0;
`endif

  assign bus.A_mul_busy   = a_valid;
  assign bus.W_mul_wr_en  = w_wr_en;
  assign bus.W_dst_regnum = w_dst;
  assign bus.W_mul_result = w_result;

endmodule

// File: tb/tb_qsys_cpu_cpu_mul_combine.sv
// tb/tb_qsys_cpu_cpu_mul_combine.sv - directed and random checks of the multiply combine stage
module tb_qsys_cpu_cpu_mul_combine;

  logic clk;
  logic reset_n;

  qsys_cpu_cpu_mul_combine_if #(.DST_W(5)) bus0 ();
  qsys_cpu_cpu_mul_combine_if #(.DST_W(5)) bus1 ();

  qsys_cpu_cpu_mul_combine #(.DST_W(5), .PIPE_COMBINE(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );
  qsys_cpu_cpu_mul_combine #(.DST_W(5), .PIPE_COMBINE(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );

  assign bus1.M_en           = bus0.M_en;
  assign bus1.A_en           = bus0.A_en;
  assign bus1.M_valid        = bus0.M_valid;
  assign bus1.M_ctrl_mul_lsw = bus0.M_ctrl_mul_lsw;
  assign bus1.M_dst_regnum   = bus0.M_dst_regnum;
  assign bus1.M_mul_cell_p1  = bus0.M_mul_cell_p1;
  assign bus1.M_mul_cell_p2  = bus0.M_mul_cell_p2;
  assign bus1.M_mul_cell_p3  = bus0.M_mul_cell_p3;
  assign bus1.A_flush        = bus0.A_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference pipeline: one slot per stage holding the architectural product.
  logic        m_a_valid, m_w_en;
  logic [4:0]  m_a_dst, m_w_dst;
  logic [31:0] m_a_res, m_w_res, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a_valid = 0; m_a_dst = 0; m_a_res = 0;
    m_w_en = 0; m_w_dst = 0; m_w_res = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_cnt;
`ifdef QSYS_CPU_MUL_PERF_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk({tag, ".wr_en"},  {31'd0, bus0.W_mul_wr_en}, {31'd0, m_w_en});
    chk({tag, ".dst"},    {27'd0, bus0.W_dst_regnum}, {27'd0, m_w_dst});
    chk({tag, ".result"}, bus0.W_mul_result, m_w_res);
    chk({tag, ".busy"},   {31'd0, bus0.A_mul_busy}, {31'd0, m_a_valid});
    chk({tag, ".count"},  bus0.mul_count, exp_cnt);
    chk({tag, ".full.result"}, bus1.W_mul_result, m_w_res);
    chk({tag, ".full.wr_en"},  {31'd0, bus1.W_mul_wr_en}, {31'd0, m_w_en});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".wr_en"},  {31'd0, bus0.W_mul_wr_en}, 32'd0);
    chk({tag, ".dst"},    {27'd0, bus0.W_dst_regnum}, 32'd0);
    chk({tag, ".result"}, bus0.W_mul_result, 32'd0);
    chk({tag, ".busy"},   {31'd0, bus0.A_mul_busy}, 32'd0);
    chk({tag, ".count"},  bus0.mul_count, 32'd0);
    chk({tag, ".full.result"}, bus1.W_mul_result, 32'd0);
  endtask

  task automatic step(input string tag, input logic v, input logic lsw, input logic [4:0] dst,
                      input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                      input logic men, input logic aen, input logic fl);
    bus0.M_valid = v; bus0.M_ctrl_mul_lsw = lsw; bus0.M_dst_regnum = dst;
    bus0.M_mul_cell_p1 = p1; bus0.M_mul_cell_p2 = p2; bus0.M_mul_cell_p3 = p3;
    bus0.M_en = men; bus0.A_en = aen; bus0.A_flush = fl;
    @(posedge clk);
    if (aen) begin
      if (m_a_valid && !fl) m_cnt = m_cnt + 32'd1;
      m_w_en = m_a_valid && !fl; m_w_dst = m_a_dst; m_w_res = m_a_res;
    end else if (fl) m_w_en = 0;
    if (men) begin
      m_a_valid = v && lsw && !fl; m_a_dst = dst;
      m_a_res = p1 + ((p2 + p3) << 16);
    end else if (fl) m_a_valid = 0;
    #1;
    check_all(tag);
  endtask

  task automatic step_src(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [4:0] dst, input logic men, input logic aen, input logic fl);
    logic [31:0] p1, p2, p3;
    p1 = s1[15:0] * s2[15:0];
    p2 = s1[15:0] * s2[31:16];
    p3 = s1[31:16] * s2[15:0];
    step(tag, 1'b1, 1'b1, dst, p1, p2, p3, men, aen, fl);
  endtask

  task automatic bubble(input string tag);
    step(tag, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
  endtask

  logic [31:0] w_snap, s1, s2;

  initial begin
    reset_n = 1'b0;
    bus0.M_en = 0; bus0.A_en = 0; bus0.M_valid = 0; bus0.M_ctrl_mul_lsw = 0;
    bus0.M_dst_regnum = 0; bus0.M_mul_cell_p1 = 0; bus0.M_mul_cell_p2 = 0;
    bus0.M_mul_cell_p3 = 0; bus0.A_flush = 0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    step("basic.m", 1, 1, 5'd7, 32'h8, 32'hA, 32'hC, 1, 1, 0);
    chk("basic.busy_abs", {31'd0, bus0.A_mul_busy}, 32'd1);
    bubble("basic.a");
    chk("basic.result_abs", bus0.W_mul_result, 32'h00160008);
    chk("basic.dst_abs", {27'd0, bus0.W_dst_regnum}, 32'd7);

    step("ones.m", 1, 1, 5'd3, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1, 1, 0);
    step("wrap.m", 1, 1, 5'd4, 32'hFFFFFFFF, 32'h00010001, 32'h0000FFFF, 1, 1, 0);
    chk("ones.result_abs", bus0.W_mul_result, 32'h00000001);
    bubble("wrap.a");
    chk("wrap.result_abs", bus0.W_mul_result, 32'hFFFFFFFF);
    chk("wrap.full_abs", bus1.W_mul_result, 32'hFFFFFFFF);
    bubble("drain");

    step_src("stall.m", 32'h12345678, 32'h9ABCDEF0, 5'd9, 1, 1, 0);
    w_snap = bus0.W_mul_result;
    for (int i = 0; i < 3; i++) begin
      step("stall.hold", 1, 1, 5'd1, 32'h1, 32'h2, 32'h3, 0, 0, 0);
      chk("stall.busy_abs", {31'd0, bus0.A_mul_busy}, 32'd1);
      chk("stall.w_held", bus0.W_mul_result, w_snap);
    end
    step("stall.release", 0, 0, 5'd0, 0, 0, 0, 0, 1, 0);
    chk("stall.result_abs", bus0.W_mul_result, 32'h12345678 * 32'h9ABCDEF0);

    step_src("flush.m", 32'h00000011, 32'h00000022, 5'd5, 1, 1, 0);
    step_src("flush.kill", 32'h00000033, 32'h00000044, 5'd6, 1, 1, 1);
    chk("flush.wr_en_abs", {31'd0, bus0.W_mul_wr_en}, 32'd0);
    chk("flush.busy_abs", {31'd0, bus0.A_mul_busy}, 32'd0);
    step("nonmul.m", 1, 0, 5'd8, 32'h5, 32'h6, 32'h7, 1, 1, 0);
    bubble("nonmul.a");
    chk("nonmul.wr_en_abs", {31'd0, bus0.W_mul_wr_en}, 32'd0);

    for (int i = 0; i < 5; i++) step_src("cnt.m", i + 1, i + 2, 5'd2, 1, 1, 0);
    step_src("cnt.flushed", 32'h7, 32'h9, 5'd2, 1, 1, 0);
    step("cnt.kill", 0, 0, 5'd0, 0, 0, 0, 1, 1, 1);
    bubble("cnt.drain");

    for (int i = 0; i < 300; i++) begin
      s1 = $urandom; s2 = $urandom;
      if ($urandom_range(0, 3) == 0)
        step("rand.raw", $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      else
        step_src("rand.src", s1, s2, 5'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    step_src("areset.m", 32'hCAFEF00D, 32'h0BADBEEF, 5'd31, 1, 1, 0);
    step_src("areset.m2", 32'h1, 32'h2, 5'd30, 1, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("areset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    bubble("areset.after");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/qsys_cpu_cpu_mul_combine.md
Name: qsys_cpu_cpu_mul_combine

Overview:
Downstream of the Nios II multiplier cell. It consumes the three registered 16x16 partial products available in M stage: p1 = lo*lo, p2 = src1.lo*src2.hi, p3 = src1.hi*src2.lo. It reduces them to the 32-bit low-word product (mul/muli) over the A and W pipeline stages. It tracks validity, destination register, stalls and flushes alongside the main pipeline and presents the result for W-stage register-file write.

Parameters:
DST_W, 5, destination register number width.
PIPE_COMBINE, 1, 1: split the add across A (upper-half sum) and W (concatenate); 0: full 32-bit sum in A, W registers only. Latency and outputs are identical for both settings.

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
M_en  in  1  M->A advance enable (same enable that clocks the mult cell registers)
A_en  in  1  A->W advance enable
M_valid  in  1  M-stage instruction valid
M_ctrl_mul_lsw  in  1  M-stage instruction is a low-word multiply
M_dst_regnum  in  DST_W  M-stage destination register
M_mul_cell_p1  in  32  partial product lo*lo
M_mul_cell_p2  in  32  partial product src1.lo*src2.hi
M_mul_cell_p3  in  32  partial product src1.hi*src2.lo
A_flush  in  1  kill all in-flight multiplies (exception/branch-mispredict)
A_mul_busy  out  1  a valid multiply occupies A stage (interlock for dependent instructions)
W_mul_wr_en  out  1  W-stage multiply result write enable
W_dst_regnum  out  DST_W  W-stage destination register
W_mul_result  out  32  low 32 bits of src1*src2
mul_count  out  32  completed-multiply counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on reset_n. All state resets to 0, so every output reads 0 during and after reset until the first capture.
- A capture, on clk edge with M_en=1:
  - A_valid <= M_valid & M_ctrl_mul_lsw & ~A_flush.
  - A_dst <= M_dst_regnum.
  - A_lo16 <= p1[15:0].
  - A_hi16 <= (p1[31:16] + p2[15:0] + p3[15:0]) mod 2^16. Carries above bit 15 are discarded. p2[31:16] and p3[31:16] are ignored.
  - With PIPE_COMBINE=0, A holds the full 32-bit sum p1 + ((p2+p3)<<16) mod 2^32 instead.
- A hold: M_en=0 holds A contents. Exception: A_flush=1 clears A_valid on that edge regardless of M_en.
- W capture, on clk edge with A_en=1:
  - W_mul_wr_en <= A_valid & ~A_flush.
  - W_dst_regnum <= A_dst.
  - W_mul_result <= {A_hi16, A_lo16}.
- W hold: A_en=0 holds all W outputs. A_flush=1 with A_en=0 also clears W_mul_wr_en.
- A_mul_busy = A_valid. Registered state, no combinational path from inputs.
- Latency: result appears on W_mul_result 2 enabled edges after M-stage presentation, i.e. one M_en edge then one A_en edge. Back-to-back multiplies sustain 1 per cycle when both enables are high.
- Simultaneous M_en, A_en and A_flush: both the entering and the advancing multiply are killed; the data registers may still load, but W_mul_wr_en=0.
- Reset mid-operation: all valids drop immediately (asynchronous). No partial result is written.
- Signedness: the low 32-bit product is sign-agnostic. No sign handling is required.

Optional Feature:
QSYS_CPU_MUL_PERF_CNT_EN
- Defined: 32-bit register mul_count, reset 0. Increments by 1 on each edge where A_en=1, A_valid=1 and A_flush=0. Wraps 0xFFFFFFFF -> 0x00000000.
- Undefined: no counter register is built and mul_count is tied to 0.

Test Plan:
- Basic product: src1=0x00030002, src2=0x00050004 (p1=0x8, p2=0xA, p3=0xC), M_valid=1, lsw=1, dst=7, M_en=A_en=1 -> W_mul_result=0x00160008, W_mul_wr_en=1, W_dst_regnum=7 two edges later.
- All-ones: p1=p2=p3=0xFFFE0001 -> W_mul_result=0x00000001 (upper-half sum 0x10000 truncated).
- Wrap: p1=0xFFFFFFFF, p2=0x00010001, p3=0x0000FFFF -> W_mul_result=0xFFFFFFFF; repeat with PIPE_COMBINE=0, result must be identical.
- Stall: A_en=0 for 3 cycles with a valid multiply in A -> A_mul_busy=1 and W outputs unchanged; A_en=1 -> result appears on the next edge.
- Flush: A_flush=1 on the edge a multiply would advance to W -> W_mul_wr_en=0, A_mul_busy=0; non-mul (lsw=0) instructions never assert W_mul_wr_en.
- Reset and counter: assert reset_n=0 mid-stream -> all outputs 0 asynchronously. With QSYS_CPU_MUL_PERF_CNT_EN, 5 completed multiplies plus 1 flushed -> mul_count=5; preload near 0xFFFFFFFF and complete one -> wraps to 0.
